// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCKED)
//   STAT_W      : width of each per-requester beat counter
//   mod_inc     : increment modulo n, used to advance the round-robin pointer
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Purely combinational rotating priority encoder. Searches i_req starting at
// index i_ptr, moving upward and wrapping modulo NUM_REQ, and returns the
// first set bit.
//   i_req [NUM_REQ]  request vector
//   i_ptr [IDX_W]    index holding highest priority
//   o_idx [IDX_W]    winning index (0 when o_any is low)
//   o_any            at least one request present
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    logic [IDX_W-1:0] v_cand;
    v_cand = '0;
    o_idx  = '0;
    o_any  = |i_req;
    // Walk from the lowest priority offset down to offset 0 so the
    // closest requester to i_ptr is the last one written and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[v_cand]) o_idx = v_cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin, packet-locking arbiter sharing the single write port of a
// FIFO between NUM_REQ producers. A winner keeps the port until it delivers
// a beat with req_last. Grants are combinational (zero-cycle latency) and
// are withheld entirely while fifo_full is high.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid[N]    per-requester beat valid
//   req_last[N]     per-requester last beat of packet (qualified by valid)
//   req_data[N*W]   packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready[N]    one-hot-or-zero accept
//   fifo_full       FIFO full flag (registered inside the FIFO)
//   fifo_wr         FIFO write strobe
//   fifo_din[W]     FIFO write data, 0 when fifo_wr is low
//   owner           current / last granted requester index
//   locked          FSM state: high while a multi-beat packet is open
//
// Optional feature, enabled by defining FIFO_WR_ARB_STATS_EN:
//   stat_clr        clear all beat counters (wins over a same-cycle increment)
//   stat_cnt[N*16]  per-requester saturating counts of accepted beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        locked
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [NUM_REQ*STAT_W-1:0]   stat_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_sel;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Handshake: a beat from requester i moves on the posedge where
  // req_valid[i] & req_ready[i] is high; that same edge is the FIFO's write.
  // fifo_wr is therefore exactly "a beat was accepted this cycle".
  always_comb begin
    req_ready   = '0;
    fifo_wr     = 1'b0;
    fifo_din    = '0;
    w_state_nxt = r_state;
    w_sel       = (r_state == LOCKED) ? r_owner : w_pick_idx;
    if (!rst && !fifo_full) begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            req_ready[w_pick_idx] = 1'b1;
            fifo_wr               = 1'b1;
            if (!req_last[w_pick_idx]) w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // The owner is offered ready even before it presents a beat.
          req_ready[r_owner] = 1'b1;
          if (req_valid[r_owner]) begin
            fifo_wr = 1'b1;
            if (req_last[r_owner]) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (fifo_wr) fifo_din = req_data[w_sel*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pointer only advances when a packet completes, so the finishing
  // requester becomes lowest priority for the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (fifo_wr) begin
      r_owner <= w_sel;
      if (req_last[w_sel]) r_rr_ptr <= IDX_W'(mod_inc(32'(w_sel), NUM_REQ));
    end
  end

  assign owner  = r_owner;
  assign locked = (r_state == LOCKED);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_cnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst || stat_clr)
        r_stat_cnt[gi] <= '0;
      else if (req_valid[gi] && req_ready[gi] && (r_stat_cnt[gi] != {STAT_W{1'b1}}))
        r_stat_cnt[gi] <= r_stat_cnt[gi] + 1'b1;
    end
    assign stat_cnt[gi*STAT_W +: STAT_W] = r_stat_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8) with a 15-entry FIFO model
// whose full flag is registered. Expected FIFO write data is queued in exp_q
// as stimulus is planned and checked in order as the DUT writes.
// Define FIFO_WR_ARB_STATS_EN to also cover the beat counters.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int DEPTH = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_wr;
  logic [W-1:0]   fifo_din;
  logic [1:0]     owner;
  logic           locked;
`ifdef FIFO_WR_ARB_STATS_EN
  logic           stat_clr;
  logic [N*16-1:0] stat_cnt;
`endif

  logic           rd_en;
  logic [W-1:0]   fifo_q[$];
  logic [W-1:0]   exp_q[$];
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .owner     (owner),
    .locked    (locked)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  // FIFO model: registered full flag, so it rises the cycle after the 15th write.
  always @(posedge clk) begin
    int sz;
    sz = fifo_q.size();
    if (rd_en && sz > 0) void'(fifo_q.pop_front());
    if (fifo_wr && sz < DEPTH) fifo_q.push_back(fifo_din);
    fifo_full <= (fifo_q.size() == DEPTH);
  end

  // Scoreboard: every DUT write is checked against the next expected beat.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (fifo_wr) begin
      total++;
      if (fifo_full) begin
        bad++;
        $display("FAIL write_while_full: fifo_wr=1 with fifo_full=1 din=%h", fifo_din);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got din=%h, expected no write", fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          bad++;
          $display("FAIL fifo_din: got %h expected %h", fifo_din, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b1;
    req_valid = '1;
    req_last = '1;
    req_data = 32'h33221100;
    step();
    step();
    total += 5;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    if (fifo_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b expected 0", fifo_wr); end
    if (fifo_din !== 8'h00) begin bad++; $display("FAIL rst_din: got %h expected 00", fifo_din); end
    if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b expected 0", locked); end
    if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner: got %0d expected 0", owner); end
    req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  // All requesters valid with single-beat packets: grants rotate 0,1,2,3.
  task automatic test_round_robin();
    int cnt[N];
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(W'((k % N) * 16 + k / N));
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 16 + cnt[i]);
      req_valid = '1;
      req_last = '1;
      #1;
      exp_rdy = N'(1) << (k % N);
      acc = req_valid & req_ready;
      total++;
      if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      step();
      total++;
      if (owner !== 2'(k % N)) begin bad++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", k, owner, k % N); end
      for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
    end
    req_valid = '0;
    step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rr_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // Requester 1 sends a 3-beat packet while requester 0 keeps requesting.
  task automatic test_lock();
    // Single beat from 0 moves the pointer to 1.
    exp_q.push_back(8'h11);
    req_valid = 4'b0001; req_last = 4'b0001; req_data = '0; req_data[7:0] = 8'h11;
    step();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'h55);
    req_valid = 4'b0011; req_last = 4'b0001; req_data[7:0] = 8'h55; req_data[15:8] = 8'hA1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_first_ready: got %b expected 0010", req_ready); end
    step();
    total += 2;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked: got %b expected 1", locked); end
    if (owner !== 2'd1) begin bad++; $display("FAIL lock_owner: got %0d expected 1", owner); end
    // Owner idles one cycle: requester 0 must still be ignored.
    req_valid = 4'b0001;
    #1;
    total += 3;
    if (fifo_wr !== 1'b0) begin bad++; $display("FAIL lock_gap_wr: got %b expected 0", fifo_wr); end
    if (fifo_din !== 8'h00) begin bad++; $display("FAIL lock_gap_din: got %h expected 00", fifo_din); end
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_gap_ready: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b0011; req_data[15:8] = 8'hA2;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_mid_ready: got %b expected 0010", req_ready); end
    step();
    req_data[15:8] = 8'hA3; req_last = 4'b0011;
    step();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_release: got %b expected 0", locked); end
    // Pointer is now 2; requesters 2,3 idle, so 0 wins ahead of 1.
    req_data[15:8] = 8'hA4;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL lock_next_ready: got %b expected 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL lock_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // FIFO fills with no reads; acceptance resumes when reads start.
  task automatic test_full();
    int n = 0;
    int writes = 0;
    int guard = 0;
    bit drained = 0;
    logic exp_rdy;
    req_valid = '0;
    rd_en = 1'b1;
    for (int i = 0; i < 40 && !drained; i++) begin
      step();
      drained = (fifo_q.size() == 0) && !fifo_full;
    end
    total++;
    if (!drained) begin bad++; $display("FAIL full_predrain: got size %0d expected 0", fifo_q.size()); end
    rd_en = 1'b0;
    for (int k = 0; k < 20; k++) exp_q.push_back(W'(8'h80 + k));
    req_last = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      req_valid = 4'b0001;
      req_data[7:0] = W'(8'h80 + n);
      #1;
      exp_rdy = (k < DEPTH);
      total++;
      if (req_ready[0] !== exp_rdy) begin bad++; $display("FAIL full_ready[%0d]: got %b expected %b", k, req_ready[0], exp_rdy); end
      if (fifo_wr) writes++;
      if (req_valid[0] && req_ready[0]) n++;
      step();
    end
    total++;
    if (writes != DEPTH) begin bad++; $display("FAIL full_writes: got %0d expected %0d", writes, DEPTH); end
    rd_en = 1'b1;
    while (n < 20 && guard < 100) begin
      req_data[7:0] = W'(8'h80 + n);
      #1;
      if (req_valid[0] && req_ready[0]) n++;
      step();
      guard++;
    end
    req_valid = '0;
    total++;
    if (n != 20) begin bad++; $display("FAIL full_resume: got %0d beats expected 20", n); end
    step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // Reset while requester 2 holds the lock.
  task automatic test_reset_mid();
    exp_q.push_back(8'hC1);
    req_valid = 4'b0100; req_last = 4'b0000; req_data = '0; req_data[23:16] = 8'hC1;
    step();
    total += 2;
    if (locked !== 1'b1) begin bad++; $display("FAIL rmid_locked: got %b expected 1", locked); end
    if (owner !== 2'd2) begin bad++; $display("FAIL rmid_owner: got %0d expected 2", owner); end
    rst = 1'b1;
    req_data[23:16] = 8'hC2;
    #1;
    total++;
    if (fifo_wr !== 1'b0) begin bad++; $display("FAIL rmid_wr_in_rst: got %b expected 0", fifo_wr); end
    step();
    rst = 1'b0;
    total += 2;
    if (locked !== 1'b0) begin bad++; $display("FAIL rmid_unlock: got %b expected 0", locked); end
    if (owner !== 2'd0) begin bad++; $display("FAIL rmid_owner_rst: got %0d expected 0", owner); end
    exp_q.push_back(8'h0F);
    req_valid = 4'b0101; req_last = 4'b0101; req_data[7:0] = 8'h0F;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ready: got %b expected 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    total++;
    if (stat_cnt[63:48] !== 16'd0) begin bad++; $display("FAIL stat_clr_init: got %0d expected 0", stat_cnt[63:48]); end
    req_valid = 4'b1000; req_last = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(W'(8'hD0 + k));
      req_data[31:24] = W'(8'hD0 + k);
      step();
    end
    req_valid = '0;
    total += 2;
    if (stat_cnt[63:48] !== 16'd5) begin bad++; $display("FAIL stat_cnt3: got %0d expected 5", stat_cnt[63:48]); end
    if (stat_cnt[15:0] !== 16'd0) begin bad++; $display("FAIL stat_cnt0: got %0d expected 0", stat_cnt[15:0]); end
    exp_q.push_back(8'hD5);
    req_valid = 4'b1000; req_data[31:24] = 8'hD5; stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    total++;
    if (stat_cnt[63:48] !== 16'd0) begin bad++; $display("FAIL stat_clr_prio: got %0d expected 0", stat_cnt[63:48]); end
    exp_q.push_back(8'hD6);
    req_data[31:24] = 8'hD6;
    step();
    req_valid = '0;
    total++;
    if (stat_cnt[63:48] !== 16'd1) begin bad++; $display("FAIL stat_after_clr: got %0d expected 1", stat_cnt[63:48]); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    rd_en = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_reset_mid();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-locking arbiter that shares the single write port of the 15-entry, 8-bit FIFO between NUM_REQ producers. Each producer offers beats with a valid/ready handshake. Once a producer wins, it owns the port until it presents a beat with req_last. The arbiter drives the FIFO's wr/din directly and backs off on fifo_full. The block sits between the producers and the FIFO; the FIFO's read side is untouched.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 8: beat width; must equal the FIFO data width
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet, qualified by req_valid
- req_data  in  NUM_REQ*DATA_W  packed beats, requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot-or-zero accept
- fifo_full  in  1  FIFO full flag
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  DATA_W  FIFO write data
- owner  out  $clog2(NUM_REQ)  current/last granted requester index
- locked  out  1  high while a multi-beat packet is in progress

## Operation
- State machine with two states, IDLE and LOCKED; reset state is IDLE.
- IDLE behaviour:
  - If fifo_full=0, pick the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Assert that requester's req_ready, fifo_wr=1, and fifo_din=its data.
- IDLE transitions (on the accepted beat):
  - req_last=1: stay IDLE, rr_ptr <= winner+1 (mod NUM_REQ).
  - req_last=0: go to LOCKED, owner <= winner.
- LOCKED behaviour:
  - Only the owner can be granted.
  - req_ready[owner] = !fifo_full; fifo_wr = req_valid[owner] & !fifo_full.
  - Other requesters are ignored even if valid.
- LOCKED transition: an accepted beat with req_last=1 returns the FSM to IDLE with rr_ptr <= owner+1.
- fifo_full=1 in any state: req_ready all 0, fifo_wr=0. State and rr_ptr hold.
- A beat transfers at a posedge where req_valid[i] & req_ready[i] = 1. That is the same edge the FIFO samples wr.
- A producer must hold req_data/req_last stable while valid and not ready.
- fifo_din is 0 when fifo_wr=0.
- Reset values:
  - Registered state: state=IDLE, rr_ptr=0, owner=0, locked=0.
  - Combinational outputs forced by rst: req_ready=0, fifo_wr=0, fifo_din=0.
- Reset mid-packet drops the lock immediately. The partial packet already written stays in the FIFO.

## Timing
- Grant is combinational from req_valid/fifo_full and registered state: zero-cycle request-to-write latency.
- Throughput is 1 beat/cycle while fifo_full=0.
- fifo_full is registered in the FIFO, so it rises the cycle after the 15th write. The arbiter must never issue a write while full=1. A write issued while full=0 is always accepted.
- Fairness: after a packet from requester i completes, requester i has lowest priority on the next IDLE arbitration.
- With all valid and single-beat packets, grants rotate 0,1,2,3,0,...

## Configuration
- FIFO_WR_ARB_STATS_EN
- With the macro defined:
  - Add input stat_clr (1 bit) and output stat_cnt (NUM_REQ*16).
  - stat_cnt holds per-requester saturating 16-bit counts of accepted beats.
  - Counts reset to 0 on rst or stat_clr. stat_clr has priority over an increment in the same cycle.
  - Counts saturate at 16'hFFFF.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package fifo_arb_pkg contains:
  - The state enum (IDLE, LOCKED).
  - STAT_W=16.
  - A function for modulo-NUM_REQ increment.
- Sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: grant index and any-grant flag.
  - Instantiated once.

## Test plan
- Reset mid-packet: requester 2 locked, assert rst 1 cycle -> next cycle locked=0, rr_ptr=0, requester 0 wins if valid.
- All 4 valid, req_last=1 always, data i*16+n -> FIFO receives 0x00,0x10,0x20,0x30,0x01,... and owner cycles 0,1,2,3.
- Requester 1 sends 3-beat packet (0xA1,0xA2,0xA3 last) while requester 0 is valid -> three consecutive writes from 1, then requester 2 or 0 per rr_ptr=2.
- No reads, requester 0 streams 20 beats -> exactly 15 fifo_wr pulses, req_ready[0]=0 from cycle 16 on, no write while full=1. Enabling reads resumes acceptance with no lost or duplicated beat.
- With FIFO_WR_ARB_STATS_EN: 5 beats from requester 3 -> stat_cnt[3]=5; stat_clr coincident with a beat -> count 0.
